// File: rtl/grf_sb.sv
// Multi-port general register file with write-through bypass and a
// single-outstanding pending scoreboard for decode-stage RAW detection.
module grf_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int TRACE    = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rdReg,
  output logic [NUM_RD*DATA_W-1:0]   rdData,
  output logic [NUM_RD-1:0]          rdBusy,
  input  logic                       issueEnable,
  input  logic [ADDR_W-1:0]          issueReg,
  input  logic                       weA,
  input  logic [ADDR_W-1:0]          wRegA,
  input  logic [DATA_W-1:0]          wDataA,
  input  logic [31:0]                pcA,
  input  logic                       weB,
  input  logic [ADDR_W-1:0]          wRegB,
  input  logic [DATA_W-1:0]          wDataB,
  input  logic [31:0]                pcB,
  output logic [ADDR_W:0]            busyCount
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0] regFile [DEPTH];
  logic [DEPTH-1:0]  pendingReg;
  logic [DEPTH-1:0]  pendingNext;
  logic [ADDR_W:0]   busyCountReg;
  logic [ADDR_W:0]   busyCountNext;

  logic commitA;
  logic commitB;
  logic issueValid;

  // Register 0 is hard-wired when HAS_ZERO: writes and issues to it vanish.
  assign commitA    = weA && !(HAS_ZERO && (wRegA == '0));
  assign commitB    = weB && !(HAS_ZERO && (wRegB == '0));
  assign issueValid = issueEnable && !(HAS_ZERO && (issueReg == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regFile[i] <= '0;
      end
      pendingReg   <= '0;
      busyCountReg <= '0;
    end else begin
      if (commitA) regFile[wRegA] <= wDataA;
      if (commitB) regFile[wRegB] <= wDataB;
      pendingReg   <= pendingNext;
      busyCountReg <= busyCountNext;
    end
  end

  // A new producer outranks a retiring one for the same register.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : gPending
    localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
    logic issueHit;
    logic writeHit;
    assign issueHit = issueValid && (issueReg == IDX);
    assign writeHit = (commitA && (wRegA == IDX)) || (commitB && (wRegB == IDX));
    assign pendingNext[gi] = issueHit ? 1'b1 : (writeHit ? 1'b0 : pendingReg[gi]);
  end

  always_comb begin
    busyCountNext = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busyCountNext = busyCountNext + (ADDR_W+1)'(pendingNext[i]);
    end
  end

  assign busyCount = busyCountReg;

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : gRead
    logic [ADDR_W-1:0] idx;
    logic              isZero;
    logic              hitA;
    logic              hitB;
    logic [DATA_W-1:0] word;

    assign idx    = rdReg[gi*ADDR_W +: ADDR_W];
    assign isZero = HAS_ZERO && (idx == '0);
    assign hitA   = commitA && (wRegA == idx);
    assign hitB   = commitB && (wRegB == idx);

    always_comb begin
      word = regFile[idx];
      if (isZero)    word = '0;
      else if (hitB) word = wDataB;
      else if (hitA) word = wDataA;
    end

    assign rdData[gi*DATA_W +: DATA_W] = word;
    assign rdBusy[gi] = pendingReg[idx] && !hitA && !hitB && !isZero;
  end

  if (TRACE != 0) begin : gTrace
`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
      if (!reset) begin
        if (commitA && !$isunknown(wDataA))
          $display("%d@%h: $%d <= %h", $time, pcA, wRegA, wDataA);
        if (commitB && !$isunknown(wDataB))
          $display("%d@%h: $%d <= %h", $time, pcB, wRegB, wDataB);
      end
    end
`endif
  end

endmodule
